// File: rtl/matinv2_pkg.sv
// Shared definitions for the 2x2 fixed-point matrix inverse: controller states and step counts.
package matinv2_pkg;

    localparam int MATRIX_N = 2;
    localparam logic [2:0] DET_LAST = 3'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DET,
        ST_CHK,
        ST_DIV,
        ST_SCALE,
        ST_FIN
    } state_t;

endpackage

// File: rtl/fxp_div.sv
// Unsigned restoring divider, 2*DATA_WIDTH-bit numerator by DATA_WIDTH-bit divisor, one quotient bit per cycle.
// start loads operands; done is high during the final step, quotient valid the cycle after and held.
module fxp_div #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [2*DATA_WIDTH-1:0] num,
    input  logic [DATA_WIDTH-1:0]   den,
    output logic                    done,
    output logic [2*DATA_WIDTH-1:0] quo
);
    localparam int DW = DATA_WIDTH;
    localparam int CW = $clog2(2 * DW);
    localparam logic [CW-1:0] LAST = CW'(2 * DW - 1);

    logic [DW-1:0]   rem_q, rem_d;
    logic [2*DW-1:0] quo_q, quo_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            run_q, run_d;
    logic [DW:0]     rem_sh;
    logic            ge;

    always_comb begin
        rem_d  = rem_q;
        quo_d  = quo_q;
        cnt_d  = cnt_q;
        run_d  = run_q;
        // Remainder stays below the divisor, so DW bits hold it between steps.
        rem_sh = {rem_q, quo_q[2*DW-1]};
        ge     = rem_sh >= {1'b0, den};
        if (start) begin
            rem_d = '0;
            quo_d = num;
            cnt_d = '0;
            run_d = 1'b1;
        end else if (run_q) begin
            rem_d = ge ? DW'(rem_sh - {1'b0, den}) : DW'(rem_sh);
            quo_d = {quo_q[2*DW-2:0], ge};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
                run_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q <= '0;
            quo_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_d;
            run_q <= run_d;
        end
    end

    assign done = run_q && (cnt_q == LAST);
    assign quo  = quo_q;

endmodule

// File: rtl/fxp_mul.sv
// Signed fixed-point multiply, product >>> BIN_POS truncated to DATA_WIDTH; one registered cycle.
// No handshake: a new operand pair may be presented every cycle.
module fxp_mul #(
    parameter int DATA_WIDTH = 16,
    parameter int BIN_POS    = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic signed [DATA_WIDTH-1:0] op_a,
    input  logic signed [DATA_WIDTH-1:0] op_b,
    output logic signed [DATA_WIDTH-1:0] prod
);
    localparam int DW = DATA_WIDTH;

    logic signed [2*DW-1:0] a_ext;
    logic signed [2*DW-1:0] b_ext;
    logic signed [2*DW-1:0] full;
    logic        [DW-1:0]   prod_d;
    logic        [DW-1:0]   prod_q;

    always_comb begin
        a_ext  = {{DW{op_a[DW-1]}}, op_a};
        b_ext  = {{DW{op_b[DW-1]}}, op_b};
        full   = a_ext * b_ext;
        prod_d = DW'(full >>> BIN_POS);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod_q <= '0;
        end else begin
            prod_q <= prod_d;
        end
    end

    assign prod = prod_q;

endmodule

// File: rtl/matinv2.sv
// Sequential 2x2 fixed-point matrix inverse; complete 2*DATA_WIDTH+10 edges after accept (5 if singular).
// start is only taken while busy=0; requests during an operation are dropped, not queued.
module matinv2
    import matinv2_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int BIN_POS     = 8,
    parameter int MATRIX_SIZE = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [DATA_WIDTH*4-1:0] a,
    output logic                    busy,
    output logic                    complete,
    output logic                    singular,
    output logic [DATA_WIDTH-1:0]   det,
    output logic [DATA_WIDTH*4-1:0] inv
);
    localparam int DW = DATA_WIDTH;
    localparam logic [DW-1:0]   FXP_MAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0]   FXP_MIN = {1'b1, {(DW-1){1'b0}}};
    localparam logic [2*DW-1:0] QMAX    = {{(DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic [2*DW-1:0] DIV_NUM = {{(2*DW-1){1'b0}}, 1'b1} << (2 * BIN_POS);

    if (MATRIX_SIZE != MATRIX_N) begin : g_size_err
        $error("matinv2 supports only MATRIX_SIZE = 2");
    end
    if (BIN_POS >= DATA_WIDTH - 1) begin : g_bin_err
        $error("matinv2 requires BIN_POS < DATA_WIDTH-1");
    end

    state_t          state_q, state_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [4*DW-1:0] a_q, a_d;
    logic [4*DW-1:0] inv_q, inv_d;
    logic [DW-1:0]   p0_q, p0_d;
    logic [DW-1:0]   det_q, det_d;
    logic            busy_q, busy_d;
    logic            complete_q, complete_d;
    logic            singular_q, singular_d;

    logic signed [DW-1:0] a00, a01, a10, a11;
    logic signed [DW-1:0] mul_a, mul_b, mul_p;
    logic        [DW-1:0] det_abs, r_mag, r_val;
    logic        [2*DW-1:0] div_quo;
    logic                 div_start, div_done;

    assign a00 = a_q[0*DW +: DW];
    assign a01 = a_q[1*DW +: DW];
    assign a10 = a_q[2*DW +: DW];
    assign a11 = a_q[3*DW +: DW];

    function automatic logic [DW-1:0] neg_sat(input logic [DW-1:0] v);
        return (v == FXP_MIN) ? FXP_MAX : -v;
    endfunction

    fxp_mul #(.DATA_WIDTH(DW), .BIN_POS(BIN_POS)) u_mul (
        .clk  (clk),
        .rst  (rst),
        .op_a (mul_a),
        .op_b (mul_b),
        .prod (mul_p)
    );

    fxp_div #(.DATA_WIDTH(DW)) u_div (
        .clk   (clk),
        .rst   (rst),
        .start (div_start),
        .num   (DIV_NUM),
        .den   (det_abs),
        .done  (div_done),
        .quo   (div_quo)
    );

    // Reciprocal: magnitude quotient saturated to +max, then the determinant's sign reapplied.
    always_comb begin
        det_abs = det_q[DW-1] ? -det_q : det_q;
        r_mag   = (div_quo > QMAX) ? FXP_MAX : div_quo[DW-1:0];
        r_val   = det_q[DW-1] ? -r_mag : r_mag;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        a_d        = a_q;
        inv_d      = inv_q;
        p0_d       = p0_q;
        det_d      = det_q;
        busy_d     = busy_q;
        complete_d = complete_q;
        singular_d = singular_q;
        mul_a      = '0;
        mul_b      = '0;
        div_start  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d        = a;
                    busy_d     = 1'b1;
                    complete_d = 1'b0;
                    singular_d = 1'b0;
                    cnt_d      = '0;
                    state_d    = ST_DET;
                end
            end
            ST_DET: begin
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == DET_LAST) begin
                    det_d   = p0_q - mul_p;
                    state_d = ST_CHK;
                end else if (cnt_q == 3'd1) begin
                    mul_a = a01;
                    mul_b = a10;
                    p0_d  = mul_p;
                end else begin
                    mul_a = a00;
                    mul_b = a11;
                end
            end
            ST_CHK: begin
                if (det_q == '0) begin
                    state_d = ST_FIN;
                end else begin
                    div_start = 1'b1;
                    state_d   = ST_DIV;
                end
            end
            ST_DIV: begin
                if (div_done) begin
                    cnt_d   = '0;
                    state_d = ST_SCALE;
                end
            end
            ST_SCALE: begin
                // Each product is captured one cycle after its operands are issued.
                mul_b = r_val;
                cnt_d = cnt_q + 3'd1;
                case (cnt_q)
                    3'd0: mul_a = a11;
                    3'd1: begin
                        mul_a            = a01;
                        inv_d[0*DW +: DW] = mul_p;
                    end
                    3'd2: begin
                        mul_a            = a10;
                        inv_d[1*DW +: DW] = neg_sat(mul_p);
                    end
                    3'd3: begin
                        mul_a            = a00;
                        inv_d[2*DW +: DW] = neg_sat(mul_p);
                    end
                    default: begin
                        inv_d[3*DW +: DW] = mul_p;
                        state_d           = ST_FIN;
                    end
                endcase
            end
            ST_FIN: begin
                busy_d     = 1'b0;
                complete_d = 1'b1;
                singular_d = (det_q == '0);
                if (det_q == '0) begin
                    inv_d = '0;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            a_q        <= '0;
            inv_q      <= '0;
            p0_q       <= '0;
            det_q      <= '0;
            busy_q     <= 1'b0;
            complete_q <= 1'b0;
            singular_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            a_q        <= a_d;
            inv_q      <= inv_d;
            p0_q       <= p0_d;
            det_q      <= det_d;
            busy_q     <= busy_d;
            complete_q <= complete_d;
            singular_q <= singular_d;
        end
    end

    assign busy     = busy_q;
    assign complete = complete_q;
    assign singular = singular_q;
    assign det      = det_q;
    assign inv      = inv_q;

endmodule

// File: tb/tb_matinv2.sv
// Bench for matinv2 (DATA_WIDTH=16, BIN_POS=8): vector table, expected-result queue, reset and busy corner cases.
module tb_matinv2;
    localparam int DW       = 16;
    localparam int BP       = 8;
    localparam int LAT      = 2 * DW + 10;
    localparam int LAT_SING = 5;
    localparam int BUDGET   = 80;
    localparam int NVEC     = 7;

    typedef struct {
        logic [4*DW-1:0] a;
        logic [DW-1:0]   det;
        logic [4*DW-1:0] inv;
        logic            sing;
    } vec_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [4*DW-1:0] a;
    logic            busy, complete, singular;
    logic [DW-1:0]   det;
    logic [4*DW-1:0] inv;

    vec_t vecs[NVEC];
    vec_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    matinv2 #(.DATA_WIDTH(DW), .BIN_POS(BP), .MATRIX_SIZE(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a        (a),
        .busy     (busy),
        .complete (complete),
        .singular (singular),
        .det      (det),
        .inv      (inv)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [15:0] e0, e1, e2, e3, d,
                                input logic [15:0] i0, i1, i2, i3, input logic s);
        vec_t v;
        v.a    = {e3, e2, e1, e0};
        v.det  = d;
        v.inv  = {i3, i2, i1, i0};
        v.sing = s;
        return v;
    endfunction

    // Drives start now (caller is away from the edge), then waits for complete and
    // checks against the queued expectation. intrude_edge>0 pulses start with other data.
    task automatic run_op(input vec_t v, input int intrude_edge, input logic [63:0] intrude_a);
        vec_t e;
        int   edge_n;
        int   exp_lat;
        start = 1'b1;
        a     = v.a;
        sb_q.push_back(v);
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = {$urandom, $urandom};
        check("accept_busy", busy, 1);
        check("accept_complete", complete, 0);
        edge_n = 0;
        while (!complete && edge_n < BUDGET) begin
            if (edge_n == intrude_edge - 1) begin
                start = 1'b1;
                a     = intrude_a;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            edge_n++;
        end
        e       = sb_q.pop_front();
        exp_lat = e.sing ? LAT_SING : LAT;
        check("latency", edge_n, exp_lat);
        check("det", det, e.det);
        check("inv", inv, e.inv);
        check("singular", singular, e.sing);
        check("busy_at_complete", busy, 0);
    endtask

    initial begin
        vecs[0] = mk(16'h0100, 16'h0000, 16'h0000, 16'h0100, 16'h0100,
                     16'h0100, 16'h0000, 16'h0000, 16'h0100, 1'b0);
        vecs[1] = mk(16'h0200, 16'h0000, 16'h0000, 16'h0400, 16'h0800,
                     16'h0080, 16'h0000, 16'h0000, 16'h0040, 1'b0);
        vecs[2] = mk(16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'hFE00,
                     16'hFE00, 16'h0100, 16'h0180, 16'hFF80, 1'b0);
        vecs[3] = mk(16'h0100, 16'h0200, 16'h0200, 16'h0400, 16'h0000,
                     16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b1);
        // det = 1 lsb: reciprocal saturates to +max
        vecs[4] = mk(16'h0010, 16'h0000, 16'h0000, 16'h0010, 16'h0001,
                     16'h07FF, 16'h0000, 16'h0000, 16'h07FF, 1'b0);
        // det = -1 lsb: reciprocal saturates to -max (0x8001)
        vecs[5] = mk(16'h0010, 16'h0000, 16'h0000, 16'hFFF0, 16'hFFFF,
                     16'h07FF, 16'h0000, 16'h0000, 16'hF800, 1'b0);
        // a01 = min value: negated product saturates to +max
        vecs[6] = mk(16'h0100, 16'h8000, 16'h0000, 16'h0100, 16'h0100,
                     16'h0100, 16'h7FFF, 16'h0000, 16'h0100, 1'b0);

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        #1;
        check("reset_busy", busy, 0);
        check("reset_complete", complete, 0);
        check("reset_singular", singular, 0);
        check("reset_det", det, 0);
        check("reset_inv", inv, 0);
        #20;
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < NVEC; i++) begin
            run_op(vecs[i], 0, '0);
        end

        // start pulsed at edge 10 with identity data must be ignored
        run_op(vecs[2], 10, vecs[0].a);

        // reset in the middle of the divide phase
        start = 1'b1;
        a     = vecs[1].a;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        check("mid_div_det", det, 16'h0800);
        check("mid_div_busy", busy, 1);
        #1;
        rst = 1'b1;
        #1;
        check("arst_busy", busy, 0);
        check("arst_complete", complete, 0);
        check("arst_singular", singular, 0);
        check("arst_det", det, 0);
        check("arst_inv", inv, 0);
        #3;
        rst = 1'b0;
        #2;
        run_op(vecs[0], 0, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
